// File: rtl/ray_queue_if.sv
// Ray type package and the generator/intersection handshake bundle used by ray_queue.
// `WIDTH, `PIXEL_WIDTH and `PIXEL_HEIGHT may be overridden on the command line.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 10
`endif
`ifndef PIXEL_HEIGHT
`define PIXEL_HEIGHT 9
`endif

package ray_pkg;
    // Origin plus normalized direction, signed fixed point.
    typedef struct packed {
        logic signed [`WIDTH-1:0] ox;
        logic signed [`WIDTH-1:0] oy;
        logic signed [`WIDTH-1:0] oz;
        logic signed [`WIDTH-1:0] dx;
        logic signed [`WIDTH-1:0] dy;
        logic signed [`WIDTH-1:0] dz;
    } ray_t;
endpackage

interface ray_queue_if #(
    parameter int PIXEL_WIDTH  = `PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT = `PIXEL_HEIGHT
);
    logic                    in_valid;
    ray_pkg::ray_t           in_ray;
    logic                    out_valid;
    logic                    out_ready;
    ray_pkg::ray_t           out_ray;
    logic [PIXEL_WIDTH-1:0]  out_px;
    logic [PIXEL_HEIGHT-1:0] out_py;
    logic                    out_last;

    modport master (
        output in_valid, in_ray, out_ready,
        input  out_valid, out_ray, out_px, out_py, out_last
    );

    modport slave (
        input  in_valid, in_ray, out_ready,
        output out_valid, out_ray, out_px, out_py, out_last
    );
endinterface

// File: rtl/ray_queue.sv
// ray_queue: FIFO between ray generator and intersection stage that tags each ray with its raster pixel.
// Define RAY_QUEUE_STATS_EN to build the saturating drop counter and the occupancy high-water mark.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 10
`endif
`ifndef PIXEL_HEIGHT
`define PIXEL_HEIGHT 9
`endif

module ray_queue #(
    parameter int WIDTH        = `WIDTH,
    parameter int DEPTH        = 16,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PIXEL_WIDTH  = `PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT = `PIXEL_HEIGHT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    ray_queue_if.slave               bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   max_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 6 * WIDTH;

    typedef struct packed {
        logic [RW-1:0]           ray;
        logic [PIXEL_WIDTH-1:0]  px;
        logic [PIXEL_HEIGHT-1:0] py;
        logic                    last;
    } entry_t;

    entry_t                  mem [DEPTH];
    entry_t                  head;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [PIXEL_WIDTH-1:0]  rx;
    logic [PIXEL_HEIGHT-1:0] ry;
    logic                    at_last;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [LW-1:0]           level_nxt;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Flush overrides both sides; a flushed in_valid is neither pushed nor dropped.
    assign pop     = !empty && bus.out_ready && !flush;
    assign push    = bus.in_valid && (!full || pop) && !flush;
    assign drop    = bus.in_valid && full && !pop && !flush;
    assign at_last = (rx == PIXEL_WIDTH'(H_RES - 1)) && (ry == PIXEL_HEIGHT'(V_RES - 1));

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; the head is gated by empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_ray, rx, ry, at_last};
        end
    end

    // NOTE: reset is sampled on the clock edge only, so it is the first branch of the clocked block, ahead of flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rx       <= '0;
            ry       <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rx       <= '0;
            ry       <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            if (drop) overflow <= 1'b1;
            // Raster advances on every arrival, dropped or not, to stay locked to pixel order.
            if (bus.in_valid) begin
                if (rx == PIXEL_WIDTH'(H_RES - 1)) begin
                    rx <= '0;
                    ry <= (ry == PIXEL_HEIGHT'(V_RES - 1)) ? '0 : ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        bus.out_valid = !empty;
        bus.out_ray   = '0;
        bus.out_px    = '0;
        bus.out_py    = '0;
        bus.out_last  = 1'b0;
        if (!empty) begin
            bus.out_ray  = head.ray;
            bus.out_px   = head.px;
            bus.out_py   = head.py;
            bus.out_last = head.last;
        end
    end

`ifdef RAY_QUEUE_STATS_EN
    logic [15:0]   drop_q;
    logic [LW-1:0] max_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_q <= '0;
            max_q  <= '0;
        end else if (flush) begin
            drop_q <= '0;
            max_q  <= '0;
        end else begin
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
            if (level_nxt > max_q) max_q <= level_nxt;
        end
    end

    assign drop_count = drop_q;
    assign max_level  = max_q;
`else
    assign drop_count = '0;
    assign max_level  = '0;
`endif

endmodule

// File: doc/ray_queue.md
RAY_QUEUE -- requirements
Module: ray_queue

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH, fixed-point component width matching the Ray struct.
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of two, >=4).
REQ-003 SHALL have parameter H_RES, default 640, and parameter V_RES, default 480: raster dimensions.
REQ-004 SHALL have parameter PIXEL_WIDTH, default `PIXEL_WIDTH, and parameter PIXEL_HEIGHT, default `PIXEL_HEIGHT: tag widths.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port reset, input, 1: reset is synchronous and active-low.
REQ-007 Port flush, input, 1: synchronous queue and raster clear.
REQ-008 Port in_valid, input, 1: ray generator output strobe; no backpressure to source.
REQ-009 Port in_ray, input, Ray: origin plus normalized direction.
REQ-010 Port out_valid, output, 1: head entry available.
REQ-011 Port out_ready, input, 1: intersection stage accepts head.
REQ-012 Port out_ray, output, Ray: head ray.
REQ-013 Port out_px, output, PIXEL_WIDTH: head pixel x. Port out_py, output, PIXEL_HEIGHT: head pixel y.
REQ-014 Port out_last, output, 1: head is pixel (H_RES-1, V_RES-1).
REQ-015 Port level, output, $clog2(DEPTH)+1: current occupancy. Ports full and empty, output, 1 each.
REQ-016 Port overflow, output, 1: sticky flag set when a ray is dropped.
REQ-017 Port drop_count, output, 16: dropped-ray count. Port max_level, output, $clog2(DEPTH)+1: high-water mark.

Function
REQ-018 Push SHALL occur when in_valid && (!full || pop) && !flush; pop SHALL occur when out_valid && out_ready.
REQ-019 Each arriving ray SHALL be tagged with the raster counter (rx, ry): rx increments 0..H_RES-1, and on wrap rx=0 with ry incrementing 0..V_RES-1 and wrapping to 0.
REQ-020 The raster counter SHALL advance on every in_valid (pushed or dropped) when !flush, so later tags stay aligned with pixel order.
REQ-021 A dropped ray (in_valid && full && !pop) SHALL set overflow and SHALL NOT alter queue contents.
REQ-022 Latency SHALL be one cycle: a ray pushed into an empty queue at edge N SHALL be presented with out_valid=1 after edge N.
REQ-023 out_ray/out_px/out_py/out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 Order SHALL be FIFO; simultaneous push and pop SHALL leave level unchanged, including at full and at level 1.
REQ-025 full SHALL be (level==DEPTH), empty SHALL be (level==0), and out_valid SHALL equal !empty.
REQ-026 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 flush SHALL empty the queue, zero the raster counter, and clear overflow, drop_count and max_level on the next edge; flush SHALL override a concurrent push and pop, and that in_valid SHALL neither count as a drop nor advance the raster.

Reset
REQ-028 With reset=0 at an edge: level=0, pointers=0, raster=(0,0), out_valid=0, overflow=0, drop_count=0, max_level=0; out_ray/out_px/out_py=0 and out_last=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries within one edge and SHALL take priority over flush and in_valid.

Configuration
REQ-030 Macro RAY_QUEUE_STATS_EN defined: drop_count SHALL increment, saturating at 16'hFFFF, on each drop, and max_level SHALL track the maximum level since reset or flush.
REQ-031 Macro RAY_QUEUE_STATS_EN undefined: drop_count and max_level SHALL be constant 0, with no counter registers synthesized; ports SHALL remain present.

Verification
REQ-032 Reset, then one in_valid with out_ready=1 -> next cycle out_valid=1, out_px=0, out_py=0, out_last=0; following cycle empty=1.
REQ-033 640 consecutive in_valid with out_ready=1 -> 640th output out_px=639, out_py=0; 641st output out_px=0, out_py=1.
REQ-034 out_ready=0 and DEPTH+3 pushes with DEPTH=16 -> full=1 and level=16; overflow=1; drop_count=3 with STATS_EN defined, 0 without; drained tags are px 0..15; next pushed ray is tagged px=19.
REQ-035 Queue full, then in_valid and out_ready high together for 5 cycles -> level stays 16, no drops, output order preserved.
REQ-036 Full frame of 307200 rays, never stalled -> exactly one out_last=1 at (639,479), after which the next tag is (0,0).
REQ-037 flush asserted with in_valid=1 and level=7 -> next cycle empty=1, overflow=0, max_level=0, raster (0,0); next ray is tagged (0,0).
